// File: rtl/sha256_mem_responder.sv
// SHA-256 engine memory with host port and 8-word digest capture; SHA_MEM_ACC_COUNT_EN adds access counters.
// Reads return one cycle later; no backpressure: engine accesses every cycle, host writes override engine writes.
module sha256_mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] OOB_DATA   = 32'hDEADBEEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          mem_we,
  input  logic [15:0]   mem_addr,
  input  logic [31:0]   mem_write_data,
  output logic [31:0]   mem_read_data,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [15:0]   host_addr,
  input  logic [31:0]   host_wdata,
  output logic [31:0]   host_rdata,
  input  logic [15:0]   digest_base,
  input  logic          digest_clear,
  output logic [255:0]  digest,
  output logic          digest_valid,
`ifdef SHA_MEM_ACC_COUNT_EN
  output logic [15:0]   rd_count,
  output logic [15:0]   wr_count,
`endif
  output logic          oob_err,
  output logic          conflict
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {CAPTURING, COMPLETE} cap_state_t;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] eng_idx;
  logic [DEPTH_LOG2-1:0] host_idx;
  logic                  eng_in_range;
  logic                  host_in_range;
  logic                  host_wr;
  logic                  eng_wr;
  logic [15:0]           win_off;
  logic                  win_hit;
  logic [2:0]            win_idx;
  logic [7:0]            mask;
  logic [7:0]            mask_nxt;
  logic [0:7][31:0]      dig;
  cap_state_t            state;
  cap_state_t            state_nxt;

  assign eng_idx       = mem_addr[DEPTH_LOG2-1:0];
  assign host_idx      = host_addr[DEPTH_LOG2-1:0];
  assign eng_in_range  = (mem_addr >> DEPTH_LOG2) == 16'd0;
  assign host_in_range = (host_addr >> DEPTH_LOG2) == 16'd0;
  assign host_wr       = host_req && host_we;
  assign eng_wr        = mem_we && !host_wr;

  // Window offset uses 16-bit wraparound so a window straddling 16'hFFFF still hits.
  assign win_off = mem_addr - digest_base;
  assign win_hit = eng_wr && (win_off[15:3] == 13'd0);
  assign win_idx = win_off[2:0];

  assign digest       = dig;
  assign digest_valid = (state == COMPLETE);

  // Single write port; storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (host_wr && host_in_range) begin
      mem[host_idx] <= host_wdata;
    end else if (eng_wr && eng_in_range) begin
      mem[eng_idx] <= mem_write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_read_data <= '0;
      host_rdata    <= '0;
      oob_err       <= 1'b0;
      conflict      <= 1'b0;
      dig           <= '0;
      mask          <= '0;
    end else begin
      mem_read_data <= eng_in_range ? mem[eng_idx] : OOB_DATA;
      if (host_req && !host_we) begin
        host_rdata <= host_in_range ? mem[host_idx] : OOB_DATA;
      end
      if (!eng_in_range) begin
        oob_err <= 1'b1;
      end
      if (mem_we && host_wr) begin
        conflict <= 1'b1;
      end
      if (win_hit) begin
        dig[win_idx] <= mem_write_data;
      end
      mask <= mask_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= CAPTURING;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    mask_nxt  = mask;
    state_nxt = state;
    if (win_hit) begin
      mask_nxt[win_idx] = 1'b1;
    end
    if (digest_clear) begin
      mask_nxt = '0;
    end
    case (state)
      CAPTURING: if (!digest_clear && mask_nxt == 8'hFF) state_nxt = COMPLETE;
      COMPLETE:  if (digest_clear) state_nxt = CAPTURING;
      default:   state_nxt = CAPTURING;
    endcase
  end

`ifdef SHA_MEM_ACC_COUNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n || digest_clear) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (!mem_we && rd_count != 16'hFFFF) begin
        rd_count <= rd_count + 16'd1;
      end
      if (eng_wr && wr_count != 16'hFFFF) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end
`endif

endmodule
